// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 Pmod keypad responder with timed press/gap sequencer; optional contact bounce via KEYPAD_BOUNCE_EN
module keypad_emulator #(
`ifdef KEYPAD_BOUNCE_EN
  parameter int BOUNCE_CYCLES = 16,
`endif
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Col,
  input  logic       press_req,
  input  logic [3:0] key_code,
  output logic [3:0] Row,
  output logic       busy,
  output logic       contact,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  key_q, key_d, row_q, row_d, rc;
  logic        busy_q, contact_q, contact_d, done_q, done_d;
  // key to matrix position {row, col}
  always_comb
    case (key_q)
      4'h1: rc = 4'h0;
      4'h2: rc = 4'h1;
      4'h3: rc = 4'h2;
      4'hA: rc = 4'h3;
      4'h4: rc = 4'h4;
      4'h5: rc = 4'h5;
      4'h6: rc = 4'h6;
      4'hB: rc = 4'h7;
      4'h7: rc = 4'h8;
      4'h8: rc = 4'h9;
      4'h9: rc = 4'hA;
      4'hC: rc = 4'hB;
      4'h0: rc = 4'hC;
      4'hF: rc = 4'hD;
      4'hE: rc = 4'hE;
      default: rc = 4'hF;
    endcase
  // press sequencer next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press_req) begin
          state_d = HOLD;
          key_d   = key_code;
        end
      end
      HOLD:
        if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      GAP:
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
`ifdef KEYPAD_BOUNCE_EN
    contact_d = ({16'd0, cnt_d} < 32'(BOUNCE_CYCLES))
              ? (state_d == HOLD ? ~cnt_d[1] : (state_d == GAP) && cnt_d[1])
              : state_d == HOLD;
`else
    contact_d = state_d == HOLD;
`endif
    row_d = (contact_q && !Col[rc[1:0]]) ? ~(4'b0001 << rc[3:2]) : 4'hF;
  end
  // state, counter and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      row_q     <= 4'hF;
      busy_q    <= 1'b0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      row_q     <= row_d;
      busy_q    <= state_d != IDLE;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  assign Row     = row_q;
  assign busy    = busy_q;
  assign contact = contact_q;
  assign done    = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed and random checks of keypad_emulator against a time-based press model
module tb_keypad_emulator;
  localparam int H = 20;
  localparam int G = 8;
`ifdef KEYPAD_BOUNCE_EN
  localparam int B = 16;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Col = 4'hF;
  logic       press_req = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] Row;
  logic       busy, contact, done;
  int         total = 0, pass = 0, dc = 0, cc = 0;
  logic       m_act = 1'b0, m_done = 1'b0;
  int         m_el = 0;
  logic [3:0] m_key = 4'h0, m_row = 4'hF;
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .Col(Col), .press_req(press_req), .key_code(key_code),
    .Row(Row), .busy(busy), .contact(contact), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic contact_at(logic act, int el);
    if (!act) return 1'b0;
`ifdef KEYPAD_BOUNCE_EN
    if (el < H) return el < B ? ((el / 2) % 2 == 0) : 1'b1;
    return (el - H) < B ? (((el - H) / 2) % 2 == 1) : 1'b0;
`else
    return el < H;
`endif
  endfunction

  function automatic int pos_of(logic [3:0] k);
    for (int i = 0; i < 16; i++) if (keymap[i] == k) return i;
    return 0;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    logic       cn;
    int         p;
    logic [3:0] nr;
    cn = contact_at(m_act, m_el);
    p  = pos_of(m_key);
    if (rst) begin
      m_act = 1'b0; m_el = 0; m_key = 4'h0; m_row = 4'hF; m_done = 1'b0;
    end else begin
      nr = 4'hF;
      if (cn && !Col[p % 4]) nr[p / 4] = 1'b0;
      m_row  = nr;
      m_done = 1'b0;
      if (m_act) begin
        m_el++;
        if (m_el == H + G) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end else if (press_req) begin
        m_act = 1'b1; m_el = 0; m_key = key_code;
      end
    end
    @(posedge clk);
    #1;
    if (done === 1'b1) dc++;
    if (contact === 1'b1) cc++;
    chk("row", 16'(Row), 16'(m_row));
    chk("busy", 16'(busy), 16'(m_act));
    chk("contact", 16'(contact), 16'(contact_at(m_act, m_el)));
    chk("done", 16'(done), 16'(m_done));
  endtask

  task automatic finish_seq();
    for (int i = 0; i < H + G + 4 && m_act; i++) tick();
    chk("seq_end", 16'(m_act), 16'd0);
  endtask

  int exp_cc;

  initial begin
    exp_cc = 0;
    for (int e = 0; e < H; e++) exp_cc += int'(contact_at(1'b1, e));
    repeat (2) tick();
    chk("rst_row", 16'(Row), 16'hF);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    foreach (keymap[i]) if (i < 4) begin
      Col = ~(4'b0001 << i);
      tick();
      chk("idle_row", 16'(Row), 16'hF);
    end
    // key 5 on column 1
    dc = 0; cc = 0;
    key_code = 4'h5; Col = 4'b1101; press_req = 1'b1;
    tick();
    press_req = 1'b0; key_code = 4'h9;
    tick();
    chk("k5_row", 16'(Row), 16'hD);
    Col = 4'b1110;
    tick();
    chk("k5_other_col", 16'(Row), 16'hF);
    finish_seq();
    tick();
    chk("k5_done_cnt", 16'(dc), 16'd1);
    chk("k5_contact_cnt", 16'(cc), 16'(exp_cc));
    // key D, multi-low columns
    key_code = 4'hD; press_req = 1'b1;
    tick();
    press_req = 1'b0; Col = 4'b0111;
    tick();
    chk("kD_row", 16'(Row), 16'h7);
    Col = 4'b0110;
    tick();
    chk("kD_multi", 16'(Row), 16'h7);
    Col = 4'b1111;
    tick();
    chk("kD_none", 16'(Row), 16'hF);
    finish_seq();
    // key 0 with ignored mid-HOLD request for key 1
    dc = 0;
    key_code = 4'h0; press_req = 1'b1;
    tick();
    press_req = 1'b0;
    repeat (5) tick();
    key_code = 4'h1; press_req = 1'b1;
    tick();
    press_req = 1'b0;
    while (m_act && m_el < 17) tick();
    Col = 4'b1110;
    tick();
    chk("k0_row", 16'(Row), 16'h7);
    finish_seq();
    repeat (3) tick();
    chk("k0_done_cnt", 16'(dc), 16'd1);
    // reset at HOLD count 10
    dc = 0;
    key_code = 4'h7; press_req = 1'b1;
    tick();
    press_req = 1'b0;
    while (m_act && m_el < 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_row", 16'(Row), 16'hF);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    chk("rst_mid_contact", 16'(contact), 16'd0);
    repeat (H + G) tick();
    chk("rst_mid_no_done", 16'(dc), 16'd0);
    key_code = 4'h8; Col = 4'b1101; press_req = 1'b1;
    tick();
    press_req = 1'b0;
    finish_seq();
    tick();
    chk("after_rst_done", 16'(dc), 16'd1);
    // held request: back-to-back sequences
    dc = 0;
    key_code = 4'hB; Col = 4'b0111; press_req = 1'b1;
    repeat (2 * (H + G) + 2) tick();
    chk("b2b_done_cnt", 16'(dc), 16'd2);
    press_req = 1'b0;
    finish_seq();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      press_req = $urandom_range(0, 7) == 0;
      key_code  = 4'($urandom);
      Col       = 4'($urandom);
      rst       = $urandom_range(0, 249) == 0;
      tick();
    end
    rst = 1'b0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
